// File: rtl/fir_pkg.sv
// +----------------------------------------------------------------------------+
// | fir_pkg                                                                    |
// | Shared widths and the scale/limit helper for the FIR result drain.         |
// | Optional macro: FIR_DRAIN_SAT_EN (clamp instead of wrap on overflow).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fir_pkg;

    localparam int ACC_W = 38;
    localparam int OUT_W = 16;

    typedef struct packed {
        logic [OUT_W-1:0] sample;
        logic             ovf;
    } sat_res_t;

    // r is the already rounded and shifted accumulator, sign-extended to ACC_W+1 bits.
    // It fits in OUT_W signed bits only if every bit from OUT_W-1 upwards is a sign copy.
    function automatic sat_res_t sat_trunc(input logic signed [ACC_W:0] r);
        logic [ACC_W-OUT_W+1:0] w_hi;
        sat_res_t               res;
        w_hi    = r[ACC_W:OUT_W-1];
        res.ovf = !((&w_hi) || !(|w_hi));
`ifdef FIR_DRAIN_SAT_EN
        if (res.ovf) begin
            res.sample = r[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            res.sample = r[OUT_W-1:0];
        end
`else
        res.sample = r[OUT_W-1:0];
`endif
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_drain_fifo.sv
// +----------------------------------------------------------------------------+
// | fir_drain_fifo                                                             |
// | DEPTH x WIDTH synchronous FIFO with combinational head and occupancy count.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_drain_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is legal then.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_result_drain.sv
// +----------------------------------------------------------------------------+
// | fir_result_drain                                                           |
// | Rounds/scales FIR accumulator results to samples and streams them out via  |
// | a small FIFO with backpressure. Optional macro: FIR_DRAIN_SAT_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_result_drain #(
    parameter int ACC_W = 38,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] in_acc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    input  logic             clear_ovf,
    output logic             ovf,
    output logic [15:0]      out_count
);

    // ACC_W/OUT_W must match the fir_pkg constants used by sat_trunc.
    import fir_pkg::*;

    localparam int                    c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic signed [ACC_W:0] c_round = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_r;
    sat_res_t              w_res;
    logic                  w_accept;
    logic                  w_pop;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic [c_cnt_w:0]      w_occupancy;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    logic                  r_stage_valid;
    logic [OUT_W-1:0]      r_stage_data;
    logic                  r_ovf;
    logic [15:0]           r_out_count;

    // One extra bit of headroom keeps the rounding add from overflowing.
    assign w_sum = $signed({in_acc[ACC_W-1], in_acc}) + c_round;
    assign w_r   = w_sum >>> SHIFT;
    assign w_res = sat_trunc(w_r);

    // Counting the in-flight stage entry guarantees every accepted value a FIFO slot.
    assign w_occupancy = {1'b0, w_fifo_count} + {{c_cnt_w{1'b0}}, r_stage_valid};
    assign in_ready    = !w_fifo_full && (w_occupancy < (c_cnt_w + 1)'(DEPTH));
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = !w_fifo_empty;
    assign w_pop       = out_valid && out_ready;
    assign ovf         = r_ovf;
    assign out_count   = r_out_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
            r_ovf         <= 1'b0;
            r_out_count   <= '0;
        end else begin
            r_stage_valid <= w_accept;
            if (w_accept) begin
                r_stage_data <= w_res.sample;
            end
            if (w_accept && w_res.ovf) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_pop) begin
                r_out_count <= r_out_count + 16'd1;
            end
        end
    end

    fir_drain_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_stage_valid),
        .i_push_data (r_stage_data),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule

`default_nettype wire
